regfile_write_ctrl: RTL and testbench
=====================================

// Module: regfile_write_ctrl
// PURPOSE
//  Write-side master for the 16x16 register_file write port (reg_write_en/dest/data).
//  Buffers writeback requests from the datapath in a small FIFO (valid/ready) and issues
//  one register write per cycle. Also provides an init sweep that loads all 16 registers
//  with a seed pattern. The sweep replaces the reset-and-read-back procedure on the read side.
// PARAMETERS
//  DATA_W      16  register data width
//  ADDR_W      4   register address width; sweep covers 2**ADDR_W registers
//  FIFO_DEPTH  4   writeback queue entries (power of 2, >=2)
//  INIT_INCR   1   value added to the seed per successive register during a sweep
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       synchronous, active-high reset
//  wb_valid        in   1       writeback request valid
//  wb_ready        out  1       queue can accept; high when count < FIFO_DEPTH
//  wb_dest         in   ADDR_W  target register
//  wb_data         in   DATA_W  value to write
//  init_start      in   1       1-cycle pulse: start an init sweep
//  init_seed       in   DATA_W  value written to register 0 of the sweep
//  init_busy       out  1       sweep in progress
//  reg_write_en    out  1       to register_file write enable
//  reg_write_dest  out  ADDR_W  to register_file write address
//  reg_write_data  out  DATA_W  to register_file write data
//  write_count     out  16      total writes issued; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs registered.
//   - reg_write_en=0, reg_write_dest=0, reg_write_data=0, init_busy=0, write_count=0.
//   - FIFO emptied; state=IDLE. wb_ready=1 in the first cycle after reset.
//  Accept: on an edge where wb_valid && wb_ready, push {wb_dest,wb_data}.
//   - wb_ready depends only on occupancy; a same-cycle pop does not raise it when full.
//  FSM:
//   - IDLE:
//     - FIFO non-empty -> pop head. reg_write_en=1, dest/data=head in the next cycle.
//     - init_start -> INIT. idx=0, val=init_seed latched.
//     - init_start and FIFO non-empty in the same cycle -> INIT wins. Queue holds; no pop.
//   - INIT:
//     - Each cycle issue reg_write_en=1, dest=idx, data=val, then idx+=1, val+=INIT_INCR (mod 2**DATA_W).
//     - After idx = 2**ADDR_W-1 is issued -> IDLE. Exactly 16 consecutive write cycles.
//     - init_busy=1 from the cycle after init_start through the last sweep write.
//     - init_start during INIT is ignored.
//     - The queue keeps accepting while not full; it drains after the sweep.
//  Latency:
//   - accept edge N -> reg_write_en high in the cycle after edge N+1 (FIFO was empty, IDLE).
//   - Throughput: 1 write/cycle sustained. No bypass path.
//  Write enable: reg_write_en is high for exactly one cycle per write; no idle gap is required
//   between back-to-back writes. dest/data are don't-care when en=0 but hold their last value.
//  Ordering: queued writes are issued in FIFO order; same-register writes are not merged.
//  write_count increments on every cycle with reg_write_en=1.
//  Reset mid-sweep or mid-drain: aborts immediately. Pending entries are lost; en=0 on the next cycle.
// TESTING
//  1. rst=1 for 2 cycles, release
//     -> en=0, count=0, wb_ready=1, init_busy=0.
//  2. init_start with seed 0x1000, INIT_INCR=1
//     -> 16 consecutive writes R0=0x1000..RF=0x100F.
//     -> read back via register_file ports 1 and 2 matches; write_count=16.
//  3. Push 4 entries (R3=0xAAAA, R5=0x5555, R3=0x1234, RF=0xFFFF) back-to-back
//     -> 4 writes issued in order; R3 ends as 0x1234; wb_ready low only while 4 held.
//  4. Hold wb_valid with the FIFO full
//     -> wb_ready=0 and no entry lost or duplicated; accepts resume after the next pop.
//  5. init_start and wb_valid(R2=0xBEEF) in the same cycle
//     -> full 16-write sweep first, then R2=0xBEEF. A second init_start mid-sweep is ignored.
//  6. rst asserted at sweep write 7 with 2 entries queued
//     -> en=0 on the next cycle, init_busy=0, count=0, FIFO empty.

Source files
------------

// File: rtl/regfile_write_ctrl_if.sv
// Writeback request, init-sweep control and register_file write-port bundle.
// The slave side is the write controller; the master side is the datapath/sweep requester.
interface regfile_write_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              init_start;
  logic [DATA_W-1:0] init_seed;
  logic              init_busy;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic [15:0]       write_count;

  modport master (
    output wb_valid, wb_dest, wb_data, init_start, init_seed,
    input  wb_ready, init_busy, reg_write_en, reg_write_dest, reg_write_data, write_count
  );

  modport slave (
    input  wb_valid, wb_dest, wb_data, init_start, init_seed,
    output wb_ready, init_busy, reg_write_en, reg_write_dest, reg_write_data, write_count
  );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Write-side master for the register_file: queues writeback requests in a small FIFO
// and issues one register write per cycle, with an init sweep loading all registers.
module regfile_write_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INIT_INCR  = 1
) (
  input logic                clk,
  input logic                rst,
  regfile_write_ctrl_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WCNT_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {IDLE, INIT} state_t;

  wb_entry_t         mem [FIFO_DEPTH];
  wb_entry_t         head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_next;
  logic              ready_q;
  logic              push, pop, fifo_empty;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  assign push          = bus.wb_valid && ready_q;
  assign fifo_empty    = (fifo_cnt == '0);
  assign head          = mem[rd_ptr];
  assign fifo_cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  // Queue storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dest: bus.wb_dest, data: bus.wb_data};
    end
  end

  // Ready is registered from next occupancy, so a pop on a full queue raises it one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt_next;
      ready_q  <= (fifo_cnt_next < CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      en_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      en_q    <= en_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Init sweep takes priority over draining; queued entries wait until the sweep ends.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    en_d    = 1'b0;
    dest_d  = dest_q;
    data_d  = data_q;
    busy_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.init_start) begin
          state_d = INIT;
          idx_d   = '0;
          val_d   = bus.init_seed;
          busy_d  = 1'b1;
        end else if (!fifo_empty) begin
          pop    = 1'b1;
          en_d   = 1'b1;
          dest_d = head.dest;
          data_d = head.data;
        end
      end
      INIT: begin
        en_d   = 1'b1;
        dest_d = idx_q;
        data_d = val_q;
        idx_d  = idx_q + ADDR_W'(1);
        val_d  = val_q + DATA_W'(INIT_INCR);
        busy_d = 1'b1;
        if (idx_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wcnt_d = wcnt_q + WCNT_W'(en_d);
  end

  assign bus.wb_ready       = ready_q;
  assign bus.init_busy      = busy_q;
  assign bus.reg_write_en   = en_q;
  assign bus.reg_write_dest = dest_q;
  assign bus.reg_write_data = data_q;
  assign bus.write_count    = wcnt_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: reset, init sweep, queued writes, full queue,
// sweep/writeback collision and reset mid-sweep, with a register-file model fed by observed writes.
module tb_regfile_write_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [19:0] wlog[$];
  logic [15:0] rf [16];

  regfile_write_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  regfile_write_ctrl #(
    .DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(4), .INIT_INCR(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge and log any write into the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.reg_write_en === 1'b1) begin
      wlog.push_back({bus.reg_write_dest, bus.reg_write_data});
      rf[bus.reg_write_dest] = bus.reg_write_data;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  d3 [4];
    logic [15:0] v3 [4];
    int n;
    d3 = '{4'h3, 4'h5, 4'h3, 4'hF};
    v3 = '{16'hAAAA, 16'h5555, 16'h1234, 16'hFFFF};

    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_dest = '0; bus.wb_data = '0;
    bus.init_start = 1'b0; bus.init_seed = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_en", 32'(bus.reg_write_en), 32'd0);
    chk("rst_count", 32'(bus.write_count), 32'd0);
    chk("rst_ready", 32'(bus.wb_ready), 32'd1);
    chk("rst_busy", 32'(bus.init_busy), 32'd0);

    // Init sweep with seed 0x1000
    bus.init_start = 1'b1; bus.init_seed = 16'h1000;
    tick();
    bus.init_start = 1'b0;
    chk("t2_busy_start", 32'(bus.init_busy), 32'd1);
    chk("t2_en_start", 32'(bus.reg_write_en), 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t2_en", 32'(bus.reg_write_en), 32'd1);
      chk("t2_dest", 32'(bus.reg_write_dest), 32'(i));
      chk("t2_data", 32'(bus.reg_write_data), 32'h1000 + 32'(i));
      chk("t2_busy", 32'(bus.init_busy), 32'd1);
    end
    tick();
    chk("t2_en_end", 32'(bus.reg_write_en), 32'd0);
    chk("t2_busy_end", 32'(bus.init_busy), 32'd0);
    chk("t2_count", 32'(bus.write_count), 32'd16);
    chk("t2_rf0", 32'(rf[0]), 32'h1000);
    chk("t2_rf7", 32'(rf[7]), 32'h1007);
    chk("t2_rf15", 32'(rf[15]), 32'h100F);

    // Four back-to-back writebacks
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      bus.wb_valid = 1'b1; bus.wb_dest = d3[k]; bus.wb_data = v3[k];
      tick();
      chk("t3_ready", 32'(bus.wb_ready), 32'd1);
      if (k == 0) chk("t3_lat_en0", 32'(bus.reg_write_en), 32'd0);
      if (k == 1) begin
        chk("t3_lat_en1", 32'(bus.reg_write_en), 32'd1);
        chk("t3_lat_dest", 32'(bus.reg_write_dest), 32'h3);
        chk("t3_lat_data", 32'(bus.reg_write_data), 32'hAAAA);
      end
    end
    bus.wb_valid = 1'b0;
    repeat (4) tick();
    chk("t3_nwrites", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wlog.size()) chk("t3_order", 32'(wlog[k]), 32'({d3[k], v3[k]}));
    end
    chk("t3_rf3", 32'(rf[3]), 32'h1234);
    chk("t3_rf5", 32'(rf[5]), 32'h5555);
    chk("t3_rf15", 32'(rf[15]), 32'hFFFF);
    chk("t3_count", 32'(bus.write_count), 32'd20);
    chk("t3_en_idle", 32'(bus.reg_write_en), 32'd0);

    // Fill the queue during a sweep and hold valid while full
    bus.init_start = 1'b1; bus.init_seed = 16'h3000;
    tick();
    bus.init_start = 1'b0;
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      bus.wb_valid = 1'b1; bus.wb_dest = 4'(8 + k); bus.wb_data = 16'(16'hC000 + k);
      tick();
      chk("t4_ready_fill", 32'(bus.wb_ready), 32'(k < 3));
    end
    bus.wb_dest = 4'hC; bus.wb_data = 16'hC004;
    n = 0;
    while (bus.wb_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_ready_cycles", 32'(n), 32'd13);
    tick();
    bus.wb_valid = 1'b0;
    repeat (6) tick();
    chk("t4_nwrites", 32'(wlog.size()), 32'd21);
    if (wlog.size() > 15) chk("t4_sweep_last", 32'(wlog[15]), 32'h F300F);
    for (int k = 0; k < 5; k++) begin
      if (16 + k < wlog.size())
        chk("t4_order", 32'(wlog[16 + k]), 32'({4'(8 + k), 16'(16'hC000 + k)}));
    end
    chk("t4_count", 32'(bus.write_count), 32'd41);

    // init_start collides with a writeback; second start mid-sweep is ignored
    bus.init_start = 1'b1; bus.init_seed = 16'h2000;
    bus.wb_valid = 1'b1; bus.wb_dest = 4'h2; bus.wb_data = 16'hBEEF;
    tick();
    bus.init_start = 1'b0; bus.wb_valid = 1'b0;
    chk("t5_busy", 32'(bus.init_busy), 32'd1);
    chk("t5_en0", 32'(bus.reg_write_en), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) bus.init_start = 1'b1;
      tick();
      bus.init_start = 1'b0;
      chk("t5_en", 32'(bus.reg_write_en), 32'd1);
      chk("t5_dest", 32'(bus.reg_write_dest), 32'(i));
      chk("t5_data", 32'(bus.reg_write_data), 32'h2000 + 32'(i));
    end
    tick();
    chk("t5_wb_en", 32'(bus.reg_write_en), 32'd1);
    chk("t5_wb_dest", 32'(bus.reg_write_dest), 32'h2);
    chk("t5_wb_data", 32'(bus.reg_write_data), 32'hBEEF);
    chk("t5_busy_end", 32'(bus.init_busy), 32'd0);
    tick();
    chk("t5_en_idle", 32'(bus.reg_write_en), 32'd0);
    chk("t5_count", 32'(bus.write_count), 32'd58);

    // Reset at sweep write 7 with two entries queued
    bus.init_start = 1'b1; bus.init_seed = 16'h4000;
    tick();
    bus.init_start = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_dest = 4'h1; bus.wb_data = 16'h1111;
    tick();
    bus.wb_dest = 4'h4; bus.wb_data = 16'h4444;
    tick();
    bus.wb_valid = 1'b0;
    repeat (6) tick();
    chk("t6_dest7", 32'(bus.reg_write_dest), 32'h7);
    chk("t6_data7", 32'(bus.reg_write_data), 32'h4007);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_en", 32'(bus.reg_write_en), 32'd0);
    chk("t6_busy", 32'(bus.init_busy), 32'd0);
    chk("t6_count", 32'(bus.write_count), 32'd0);
    chk("t6_ready", 32'(bus.wb_ready), 32'd1);
    wlog.delete();
    repeat (4) tick();
    chk("t6_no_writes", 32'(wlog.size()), 32'd0);
    chk("t6_busy_after", 32'(bus.init_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
